// File: rtl/rename_pkg.sv
// Shared rename-stage types and default widths for the free list, rename and commit.
package rename_pkg;

  localparam int TAG_W   = 8;
  localparam int DEPTH   = 32;
  localparam int ALLOC_W = 2;
  localparam int FREE_W  = 2;
  localparam int PTR_W   = $clog2(DEPTH) + 1;

  typedef logic [TAG_W-1:0] tag_t;
  // Pointers carry one extra wrap bit so that a full list and an empty list differ.
  typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/rename_free_list_compactor.sv
// Prefix popcount over the free strobes: each valid lane gets its slot offset past wr.
module free_lane_compactor
  import rename_pkg::*;
#(
  parameter int N  = FREE_W,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]    valid,
  output logic [N*CW-1:0] offset,
  output logic [CW-1:0]   count
);

  logic [CW-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int j = 0; j < N; j++) begin
      offset[j*CW +: CW] = acc;
      acc = acc + CW'(valid[j]);
    end
    count = acc;
  end

endmodule

// File: rtl/rename_free_list.sv
// Circular free list of physical tags with multi-lane alloc/free and pointer checkpoints.
module rename_free_list #(
  parameter int TAG_W     = rename_pkg::TAG_W,
  parameter int DEPTH     = rename_pkg::DEPTH,
  parameter int INIT_BASE = 0,
  parameter int ALLOC_W   = rename_pkg::ALLOC_W,
  parameter int FREE_W    = rename_pkg::FREE_W,
  parameter int NCKPT     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(ALLOC_W+1)-1:0] alloc_req,
  output logic [ALLOC_W*TAG_W-1:0]     alloc_tag,
  output logic                         alloc_grant,
  input  logic [FREE_W-1:0]            free_valid,
  input  logic [FREE_W*TAG_W-1:0]      free_tag,
  input  logic                         ckpt_save,
  input  logic [$clog2(NCKPT)-1:0]     ckpt_save_id,
  input  logic                         ckpt_restore,
  input  logic [$clog2(NCKPT)-1:0]     ckpt_restore_id,
  output logic [$clog2(DEPTH):0]       num_items,
  output logic [$clog2(DEPTH):0]       freespace,
  output logic                         err
);

  localparam int P   = $clog2(DEPTH);
  localparam int PW  = P + 1;
  localparam int PW1 = P + 2;
  localparam int CW  = $clog2(FREE_W + 1);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [P:0]       rd, wr, rd_alloc, rd_next;
  logic [P:0]       ckpt_ptr [NCKPT];
  logic [NCKPT-1:0] ckpt_valid;
  logic [FREE_W*CW-1:0] free_off;
  logic [CW-1:0]    free_cnt;
  logic [P-1:0]     free_idx [FREE_W];
  logic             overflow, restore_bad;

  free_lane_compactor #(.N(FREE_W), .CW(CW)) u_compactor (
    .valid  (free_valid),
    .offset (free_off),
    .count  (free_cnt)
  );

  assign num_items   = wr - rd;
  assign freespace   = PW'(DEPTH) - num_items;
  assign alloc_grant = (alloc_req != '0) && (PW'(alloc_req) <= num_items) && !ckpt_restore;
  assign rd_alloc    = alloc_grant ? rd + PW'(alloc_req) : rd;
  assign restore_bad = ckpt_restore && !ckpt_valid[ckpt_restore_id];
  assign rd_next     = (ckpt_restore && ckpt_valid[ckpt_restore_id]) ?
                       ckpt_ptr[ckpt_restore_id] : rd_alloc;
  assign overflow    = ({1'b0, num_items} + PW1'(free_cnt)) > PW1'(DEPTH);

  for (genvar k = 0; k < ALLOC_W; k++) begin : g_lane
    logic [P-1:0] idx;
    assign idx = rd[P-1:0] + P'(k);
    assign alloc_tag[k*TAG_W +: TAG_W] = mem[idx];
  end

  always_comb begin
    for (int j = 0; j < FREE_W; j++)
      free_idx[j] = wr[P-1:0] + P'(free_off[j*CW +: CW]);
  end

  // Restore wins over save in the same cycle; a freed tag lands behind wr, so no bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_W'(INIT_BASE + i);
      rd         <= '0;
      wr         <= PW'(DEPTH);
      ckpt_valid <= '0;
      err        <= 1'b0;
    end else begin
      for (int j = 0; j < FREE_W; j++)
        if (free_valid[j]) mem[free_idx[j]] <= free_tag[j*TAG_W +: TAG_W];
      wr <= wr + PW'(free_cnt);
      rd <= rd_next;
      if (ckpt_save && !ckpt_restore) begin
        ckpt_ptr[ckpt_save_id]   <= rd_alloc;
        ckpt_valid[ckpt_save_id] <= 1'b1;
      end
      if (overflow || restore_bad) err <= 1'b1;
    end
  end

  a_overflow_flagged: assert property (@(posedge clk) disable iff (reset)
    overflow |=> err);
  a_no_over_grant: assert property (@(posedge clk) disable iff (reset)
    (PW'(alloc_req) > num_items) |-> !alloc_grant);
  a_bad_restore_ignored: assert property (@(posedge clk) disable iff (reset)
    restore_bad |=> (err && rd == $past(rd)));

endmodule

// File: tb/tb_rename_free_list.sv
// Directed scoreboard bench for rename_free_list: driver queues expectations, monitor checks.
module tb_rename_free_list;
  import rename_pkg::*;

  localparam int NDEPTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alloc_req;
  logic [15:0] alloc_tag;
  logic        alloc_grant;
  logic [1:0]  free_valid;
  logic [15:0] free_tag;
  logic        ckpt_save;
  logic [1:0]  ckpt_save_id;
  logic        ckpt_restore;
  logic [1:0]  ckpt_restore_id;
  logic [5:0]  num_items;
  logic [5:0]  freespace;
  logic        err;

  always #5 clk = ~clk;

  rename_free_list dut (
    .clk             (clk),
    .reset           (reset),
    .alloc_req       (alloc_req),
    .alloc_tag       (alloc_tag),
    .alloc_grant     (alloc_grant),
    .free_valid      (free_valid),
    .free_tag        (free_tag),
    .ckpt_save       (ckpt_save),
    .ckpt_save_id    (ckpt_save_id),
    .ckpt_restore    (ckpt_restore),
    .ckpt_restore_id (ckpt_restore_id),
    .num_items       (num_items),
    .freespace       (freespace),
    .err             (err)
  );

  // -1 in any field means "not checked this cycle".
  typedef struct {
    int grant;
    int t0;
    int t1;
    int num;
    int err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_nm;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(string nm, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      if (mon_e.grant >= 0) chk({mon_nm, " grant"}, int'(alloc_grant), mon_e.grant);
      if (mon_e.t0 >= 0)    chk({mon_nm, " tag0"}, int'(alloc_tag[7:0]), mon_e.t0);
      if (mon_e.t1 >= 0)    chk({mon_nm, " tag1"}, int'(alloc_tag[15:8]), mon_e.t1);
      if (mon_e.num >= 0) begin
        chk({mon_nm, " num_items"}, int'(num_items), mon_e.num);
        chk({mon_nm, " freespace"}, int'(freespace), NDEPTH - mon_e.num);
      end
      if (mon_e.err >= 0)   chk({mon_nm, " err"}, int'(err), mon_e.err);
    end
  end

  task automatic step(string nm, bit rst, int req, logic [1:0] fv, int f0, int f1,
                      bit sv, int sid, bit rs, int rid,
                      int eg, int et0, int et1, int en, int ee);
    exp_t e;
    reset           = rst;
    alloc_req       = 2'(req);
    free_valid      = fv;
    free_tag        = {8'(f1), 8'(f0)};
    ckpt_save       = sv;
    ckpt_save_id    = 2'(sid);
    ckpt_restore    = rs;
    ckpt_restore_id = 2'(rid);
    e.grant = eg; e.t0 = et0; e.t1 = et1; e.num = en; e.err = ee;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step("reset", 1'b1, 0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, -1, -1, -1, -1, -1);
  endtask

  task automatic alloc(string nm, int req, int eg, int et0, int et1, int en);
    step(nm, 1'b0, req, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, eg, et0, et1, en, -1);
  endtask

  // Tag held at absolute pointer r during the wrap test: original tags below 32,
  // then the refill pattern 100+idx written by the fill loop.
  function automatic int tagf(int r);
    return (r < 32) ? r : 68 + r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; alloc_req = '0; free_valid = '0; free_tag = '0;
    ckpt_save = 1'b0; ckpt_save_id = '0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
    @(posedge clk);
    #1;
    do_reset();
    do_reset();

    // Drain the whole list two tags at a time.
    step("seq0", 1'b0, 2, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, 1, 0, 1, 32, 0);
    for (int c = 1; c < 16; c++) alloc("seq", 2, 1, 2*c, 2*c+1, 32 - 2*c);
    alloc("empty", 2, 0, -1, -1, 0);

    // Compacted frees from empty, no same-cycle bypass, all-or-nothing grant.
    step("free_b",  1'b0, 1, 2'b10, 8'hAA, 7, 1'b0, 0, 1'b0, 0, 0, -1, -1, 0, -1);
    step("free_ab", 1'b0, 2, 2'b11, 9, 3,     1'b0, 0, 1'b0, 0, 0, 7, -1, 1, -1);
    alloc("head", 1, 1, 7, -1, 3);
    alloc("pair", 2, 1, 9, 3, 2);
    alloc("drained", 1, 0, -1, -1, 0);

    // Checkpoint save/restore; the save during restore must be ignored.
    do_reset();
    alloc("pre0", 2, 1, 0, 1, 32);
    alloc("pre1", 2, 1, 2, 3, 30);
    step("save", 1'b0, 1, 2'b00, 0, 0, 1'b1, 0, 1'b0, 0, 1, 4, -1, 28, -1);
    alloc("spec0", 2, 1, 5, 6, 27);
    alloc("spec1", 2, 1, 7, 8, 25);
    alloc("spec2", 2, 1, 9, 10, 23);
    step("restore", 1'b0, 2, 2'b00, 0, 0, 1'b1, 1, 1'b1, 0, 0, -1, -1, 21, -1);
    alloc("replay0", 2, 1, 5, 6, 27);
    alloc("replay1", 2, 1, 7, 8, 25);
    alloc("replay2", 2, 1, 9, 10, 23);

    // Steady alloc+free until wr sits at 63, then wrap both pointers.
    for (int i = 0; i < 15; i++)
      step("wrap_fill", 1'b0, 2, 2'b11, 100 + 2*i, 101 + 2*i, 1'b0, 0, 1'b0, 0,
           1, tagf(11 + 2*i), tagf(12 + 2*i), 21, -1);
    step("wr_to_63", 1'b0, 0, 2'b01, 130, 0, 1'b0, 0, 1'b0, 0, 0, -1, -1, 21, -1);
    step("wrap", 1'b0, 2, 2'b11, 200, 201, 1'b0, 0, 1'b0, 0, 1, 109, 110, 22, -1);
    for (int c = 0; c < 10; c++)
      alloc("wrap_drain", 2, 1, 68 + 43 + 2*c, 69 + 43 + 2*c, 22 - 2*c);
    alloc("wrap_tags", 2, 1, 200, 201, 2);
    alloc("wrap_empty", 1, 0, -1, -1, 0);

    // Error cases: invalid restore, then free into a full list.
    do_reset();
    step("bad_restore", 1'b0, 2, 2'b00, 0, 0, 1'b0, 0, 1'b1, 2, 0, -1, -1, 32, 0);
    step("after_bad",   1'b0, 2, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, 1, 0, 1, 32, 1);
    step("err_sticky",  1'b0, 0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, -1, -1, -1, 30, 1);
    do_reset();
    step("full_free",   1'b0, 0, 2'b11, 50, 51, 1'b0, 0, 1'b0, 0, 0, -1, -1, 32, 0);
    step("ovf_err",     1'b0, 0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, -1, -1, -1, -1, 1);
    step("ovf_sticky",  1'b0, 0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, -1, -1, -1, -1, 1);
    do_reset();
    step("reset_clear", 1'b0, 0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, 0, 0, 1, 32, 0);

    chk("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rename_free_list.md
# rename_free_list

Parametrised physical-register free list for the rename stage: a circular buffer of free tags supporting up to ALLOC_W allocations and FREE_W frees per cycle, with branch checkpoint/restore of the allocation pointer. Rename pulls tags for new destinations. Commit returns old tags. Branch resolution rolls back speculative allocations in one cycle.

## Interface
- TAG_W, 8, tag width
- DEPTH, 32, entries; power of two; also the number of tags loaded at reset
- INIT_BASE, 0, first tag loaded at reset (entry i holds INIT_BASE+i)
- ALLOC_W, 2, max allocations per cycle
- FREE_W, 2, max frees per cycle
- NCKPT, 4, checkpoint slots
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- alloc_req  in  $clog2(ALLOC_W+1)  number of tags requested this cycle
- alloc_tag  out  ALLOC_W x TAG_W  tags offered; lane k = entry rd+k
- alloc_grant  out  1  request accepted this cycle
- free_valid  in  FREE_W  per-lane free strobe
- free_tag  in  FREE_W x TAG_W  tags returned
- ckpt_save  in  1  save pointer to slot ckpt_save_id
- ckpt_save_id  in  $clog2(NCKPT)
- ckpt_restore  in  1  restore pointer from slot ckpt_restore_id
- ckpt_restore_id  in  $clog2(NCKPT)
- num_items  out  $clog2(DEPTH)+1  free tags held
- freespace  out  $clog2(DEPTH)+1  DEPTH - num_items
- err  out  1  sticky error flag

## Operation
- Pointers rd and wr are $clog2(DEPTH)+1 bits and carry a wrap bit. num_items = wr - rd, computed modulo 2^(P+1). Entry index is the low P bits.
- Reset: entry i = INIT_BASE+i, rd=0, wr=DEPTH (list full), all checkpoint slots invalid, err=0. Therefore num_items=DEPTH and freespace=0.
- Allocate:
  - alloc_grant = (alloc_req != 0) && (alloc_req <= num_items) && !ckpt_restore.
  - The grant is all-or-nothing; a request is never partially served.
  - On grant, rd += alloc_req. Lanes at index alloc_req and above are don't-care.
- Free:
  - Valid lanes are compacted. Lane j writes entry wr + popcount(free_valid[j-1:0]), and wr += popcount(free_valid).
  - Free lanes need not be contiguous.
  - If a free would make num_items exceed DEPTH, err is set. Pointer and data behaviour is then undefined.
- Same-cycle allocate and free:
  - Both take effect.
  - A freed tag is not allocatable until the next cycle; there is no bypass.
  - num_items/freespace are computed from registered pointers only.
- Save: slot[ckpt_save_id] = rd value after this cycle's allocation, so it includes the branch's own destination. The slot is marked valid.
- Restore:
  - rd = slot[ckpt_restore_id].
  - Allocation is suppressed that cycle.
  - Frees in the same cycle still apply.
  - Restoring an invalid slot sets err and leaves rd unchanged.
  - A save in the same cycle as a restore is ignored.
- Wrap-around: index arithmetic is modulo DEPTH. Lane k reads entry (rd+k) mod DEPTH, and free lanes also wrap.
- err clears only on reset.

## Timing
- alloc_tag and alloc_grant are combinational from registered state and the current-cycle alloc_req/ckpt_restore. Zero-cycle offer latency.
- Pointer, data and checkpoint updates happen on the rising edge. num_items reflects them one cycle later.
- A freed tag appears at alloc_tag no earlier than the cycle after its free.
- Reset mid-operation overrides all inputs that cycle. The list returns to its initial contents.

## Structure
- Package rename_pkg:
  - TAG_W
  - tag_t
  - ptr_t, built from $clog2(DEPTH)+1
  - ALLOC_W / FREE_W defaults, shared with rename and commit
- Sub-module free_lane_compactor: combinational prefix popcount of free_valid. It produces per-lane write offsets and the total count.
- Top holds the storage array, pointers, checkpoint slots and error logic. Assertions are written in SVA:
  - no overflow
  - no grant when the request exceeds num_items
  - no restore of an invalid slot

## Test plan
- Reset, then alloc_req=2 for 16 cycles: tags 0..31 in order, all granted. The 17th cycle gives alloc_grant=0 with num_items=0.
- From empty, free_valid=2'b10 with tag 7, then 2'b11 with tags 9,3: next allocations return 7, 9, 3. num_items goes 1 then 3.
- num_items=1 and alloc_req=2: grant=0, rd unchanged. alloc_req=1 is granted and returns the head tag.
- Save at rd=4 with alloc_req=1, allocate 6 more, then restore: rd=5, num_items rises by 6, and tags 5..10 are re-offered.
- Simultaneous alloc_req=2 and free of 2 tags at wr wrapping from 31 to 0: num_items unchanged and wrap bits toggle correctly.
- Free while full, and restore of an invalid slot: err=1 and stays 1 until reset, which returns num_items to 32.
